div_seq: RTL and testbench
==========================

Name: div_seq

Overview:
- Parametrised sequential restoring divider; next generation of the 32-bit unsigned multicycle divider.
- Adds configurable width, run-time signed/unsigned mode, explicit divide-by-zero handling and a one-cycle done pulse.
- Sits beside the ALU in the multicycle CPU. The control FSM drives it for DIV/DIVU and stalls on busy.

Parameters:
- WIDTH, 32, operand, quotient and remainder width in bits; legal range 4..64.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, never overridden.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- ena  input  1  block enable; low forces the block to idle
- start  input  1  request pulse; sampled only when idle and ena=1
- sign  input  1  1 = signed (two's complement) divide, 0 = unsigned
- dividend  input  WIDTH  numerator; sampled with start
- divisor  input  WIDTH  denominator; sampled with start
- q  output  WIDTH  quotient register
- r  output  WIDTH  remainder register
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse when q and r update
- div_zero  output  1  set when the last completed operation had divisor=0

Behaviour:
- Reset: on any clock edge with reset=1, state=IDLE; q, r, busy, done, div_zero and the counter all go to 0. Reset takes priority over every other input, including in mid-operation.
- ena=0 (reset=0): state→IDLE, busy=0, done=0; q, r and div_zero hold their values. An in-flight operation is abandoned with no done pulse.
- FSM states: IDLE, CALC, FIX.
- IDLE:
  - On start=1 and ena=1, latch |dividend| and |divisor|. Magnitudes are taken only when sign=1; otherwise the raw values are used.
  - Latch neg_q = sign & (dividend MSB ^ divisor MSB) and neg_r = sign & dividend MSB.
  - Clear the 2*WIDTH partial register upper half; set busy=1 and counter=0.
  - If divisor==0, go to FIX with a dz flag set. Otherwise go to CALC.
- CALC: one restoring step per cycle.
  - Shift {rem,quo} left by 1.
  - If the upper half is >= the divisor magnitude, subtract it and set the quotient LSB.
  - Increment the counter. After WIDTH steps (counter==WIDTH-1 at the edge), go to FIX.
- FIX:
  - Normal case: q = neg_q ? -quo : quo; r = neg_r ? -rem : rem.
  - dz case: q = all ones, r = original dividend (unmodified, sign-independent), div_zero=1.
  - Normal case clears div_zero.
  - busy=0, done=1 for exactly this one cycle; state→IDLE.
- Latency: start sampled at edge E0; done and new q/r are visible after edge E0+WIDTH+1. The divide-by-zero case is visible after edge E0+1.
- Back-to-back: start may be asserted in the cycle done is high; it is accepted and done falls.
- start while busy: ignored; no restart, no error.
- Overflow (signed): most-negative / -1 gives q = most-negative and r = 0. This falls out of the magnitude wrap with no special-case logic.
- Arithmetic: all datapath ops are WIDTH bits, except the compare/subtract, which is WIDTH+1 bits so the shifted-out bit is never lost.
- q and r are always driven from registers (no high-Z); the bus owner gates them externally.

Optional Feature:
- Macro DIV_SIGNED_EN.
- Defined: sign port honoured as above.
- Undefined:
  - sign is ignored and treated as 0; the neg_q/neg_r logic and negation adders are not built.
  - The block is a pure unsigned divider with identical latency and div_zero behaviour.

Decomposition:
- Package div_pkg: state enum div_state_t {IDLE, CALC, FIX}; localparam function for counter width; constant DIV_ZERO_Q (all ones).
- Sub-module div_restoring_step: combinational single iteration.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - Instantiated once in CALC.
  - Allows later unrolling to radix-4 by instantiating two.

Test Plan:
- Unsigned, WIDTH=32, sign=0: 100 / 7 → done after 33 cycles, q=14, r=2, div_zero=0; busy high for exactly 33 cycles.
- Signed: -100 / 7 → q=-14 (0xFFFFFFF2), r=-2 (0xFFFFFFFE). 100 / -7 → q=-14, r=2. -100 / -7 → q=14, r=-2.
- Divide by zero: 0x12345678 / 0 → after 1 cycle done=1, q=0xFFFFFFFF, r=0x12345678, div_zero=1. A following 9/3 clears div_zero and gives q=3, r=0.
- Edge values: 0x80000000 / 0xFFFFFFFF signed → q=0x80000000, r=0. Same operands unsigned → q=0, r=0x80000000. 0xFFFFFFFF / 1 unsigned → q=0xFFFFFFFF, r=0.
- Control: start asserted at cycle 10 of an op is ignored (result matches the original op). Reset at cycle 5 → next cycle busy=0, q=r=0, no done. ena dropped mid-op → busy=0, no done, q/r keep prior result.
- WIDTH=8 build, with and without DIV_SIGNED_EN: 200 / 9 unsigned → q=22, r=2 after 9 cycles. With the macro undefined, sign=1 gives the identical result.

Source files
------------

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the sequential divider
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_t;

    // Iteration counter must be able to hold WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    // Quotient reported on divide-by-zero; sliced down to WIDTH by the user.
    localparam logic [63:0] DIV_ZERO_Q = '1;

endpackage

// File: rtl/div_seq_if.sv
// rtl/div_seq_if.sv - request/result bundle between the CPU control FSM and div_seq
interface div_seq_if #(
    parameter int WIDTH = 32
);
    logic             ena;
    logic             start;
    logic             sign;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output ena, start, sign, dividend, divisor,
        input  q, r, busy, done, div_zero
    );

    modport slave (
        input  ena, start, sign, dividend, divisor,
        output q, r, busy, done, div_zero
    );
endinterface

// File: rtl/div_restoring_step.sv
// rtl/div_restoring_step.sv - one combinational restoring-division iteration
module div_restoring_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic [WIDTH-1:0] next_quo
);
    // The shifted remainder is kept WIDTH+1 bits wide so its top bit survives
    // the compare; the subtract borrow (diff MSB) doubles as "rem < divisor".
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted  = {rem, quo[WIDTH-1]};
    assign diff     = shifted - {1'b0, divisor};
    assign next_rem = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign next_quo = {quo[WIDTH-2:0], ~diff[WIDTH]};
endmodule

// File: rtl/div_seq.sv
// rtl/div_seq.sv - multicycle restoring divider; DIV_SIGNED_EN enables signed mode
module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic      clock,
    input  logic      reset,
    div_seq_if.slave  bus
);
    localparam int CNT_W = cnt_width(WIDTH);

    div_state_t       state;
    div_state_t       state_nx;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] dvd_raw;
    logic             dz;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] r_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             dz_reg;

    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

`ifdef DIV_SIGNED_EN
    logic neg_q;
    logic neg_r;
    logic a_neg;
    logic b_neg;

    assign a_neg = bus.sign & bus.dividend[WIDTH-1];
    assign b_neg = bus.sign & bus.divisor[WIDTH-1];
    assign a_mag = a_neg ? -bus.dividend : bus.dividend;
    assign b_mag = b_neg ? -bus.divisor  : bus.divisor;
    assign q_fix = neg_q ? -quo : quo;
    assign r_fix = neg_r ? -rem : rem;
`else
    logic unused_sign;

    assign unused_sign = bus.sign;
    assign a_mag       = bus.dividend;
    assign b_mag       = bus.divisor;
    assign q_fix       = quo;
    assign r_fix       = rem;
`endif

    div_restoring_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (dvs),
        .next_rem (step_rem),
        .next_quo (step_quo)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next state: a zero divisor skips the iterations and goes straight to FIX.
    always_comb begin
        state_nx = state;
        if (!bus.ena) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.start) state_nx = (bus.divisor == '0) ? FIX : CALC;
                CALC:    if (cnt == CNT_W'(WIDTH - 1)) state_nx = FIX;
                FIX:     state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Datapath and result registers; done is a registered one-cycle pulse
    // that lands together with the new q/r.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            dvd_raw  <= '0;
            dz       <= 1'b0;
            q_reg    <= '0;
            r_reg    <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
            dz_reg   <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            if (!bus.ena) begin
                busy_reg <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            rem      <= '0;
                            quo      <= a_mag;
                            dvs      <= b_mag;
                            dvd_raw  <= bus.dividend;
                            dz       <= (bus.divisor == '0);
                            cnt      <= '0;
                            busy_reg <= 1'b1;
`ifdef DIV_SIGNED_EN
                            neg_q    <= a_neg ^ b_neg;
                            neg_r    <= a_neg;
`endif
                        end
                    end
                    CALC: begin
                        rem <= step_rem;
                        quo <= step_quo;
                        cnt <= cnt + 1'b1;
                    end
                    FIX: begin
                        if (dz) begin
                            q_reg  <= DIV_ZERO_Q[WIDTH-1:0];
                            r_reg  <= dvd_raw;
                            dz_reg <= 1'b1;
                        end else begin
                            q_reg  <= q_fix;
                            r_reg  <= r_fix;
                            dz_reg <= 1'b0;
                        end
                        busy_reg <= 1'b0;
                        done_reg <= 1'b1;
                    end
                    default: busy_reg <= 1'b0;
                endcase
            end
        end
    end

    assign bus.q        = q_reg;
    assign bus.r        = r_reg;
    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.div_zero = dz_reg;
endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - self-checking bench for div_seq (WIDTH=32)
module tb_div_seq;
    localparam int W = 32;
`ifdef DIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    div_seq_if #(.WIDTH(W)) bus ();

    div_seq #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division with C-style truncation.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output logic [W-1:0] eq, output logic [W-1:0] er, output logic ez);
        longint sa;
        longint sb;
        if (b == 0) begin
            eq = '1;
            er = a;
            ez = 1'b1;
        end else if (s && SIGNED_EN) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            eq = W'(sa / sb);
            er = W'(sa % sb);
            ez = 1'b0;
        end else begin
            eq = a / b;
            er = a % b;
            ez = 1'b0;
        end
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        bus.dividend = a;
        bus.divisor  = b;
        bus.sign     = s;
        bus.start    = 1'b1;
        @(posedge clock);
        #1;
        bus.start    = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = bus.busy ? 1 : 0;
        while (!bus.done && lat < 200) begin
            @(posedge clock);
            #1;
            lat++;
            if (bus.busy) busy_cnt++;
        end
    endtask

    task automatic run_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic s, input bit pulse_check);
        logic [W-1:0] eq, er;
        logic         ez;
        int           lat, bc;
        model(a, b, s, eq, er, ez);
        issue(a, b, s);
        chk({tag, " busy_after_start"}, 64'(bus.busy), 64'(1));
        chk({tag, " done_low_after_start"}, 64'(bus.done), 64'(0));
        wait_done(lat, bc);
        chk({tag, " latency"}, 64'(lat), 64'((b == 0) ? 1 : W + 1));
        chk({tag, " busy_cycles"}, 64'(bc), 64'((b == 0) ? 1 : W + 1));
        chk({tag, " q"}, 64'(bus.q), 64'(eq));
        chk({tag, " r"}, 64'(bus.r), 64'(er));
        chk({tag, " div_zero"}, 64'(bus.div_zero), 64'(ez));
        if (pulse_check) begin
            @(posedge clock);
            #1;
            chk({tag, " done_pulse"}, 64'(bus.done), 64'(0));
        end
    endtask

    initial begin
        logic [W-1:0] eq, er, a, b, hold_q, hold_r;
        logic         ez, s;
        int           lat, bc, dones;

        bus.ena      = 1'b1;
        bus.start    = 1'b0;
        bus.sign     = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;

        repeat (2) @(posedge clock);
        #1;
        chk("rst q", 64'(bus.q), 64'(0));
        chk("rst r", 64'(bus.r), 64'(0));
        chk("rst busy", 64'(bus.busy), 64'(0));
        chk("rst done", 64'(bus.done), 64'(0));
        chk("rst div_zero", 64'(bus.div_zero), 64'(0));
        reset = 1'b0;
        @(posedge clock);
        #1;

        run_check("u100_7", 32'd100, 32'd7, 1'b0, 1'b1);
        run_check("s-100_7", -32'sd100, 32'd7, 1'b1, 1'b1);
        run_check("s100_-7", 32'd100, -32'sd7, 1'b1, 1'b1);
        run_check("s-100_-7", -32'sd100, -32'sd7, 1'b1, 1'b1);
        run_check("dz", 32'h12345678, 32'd0, 1'b0, 1'b1);
        run_check("after_dz", 32'd9, 32'd3, 1'b0, 1'b1);
        run_check("s_minneg_-1", 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1);
        run_check("u_minneg_max", 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1);
        run_check("u_max_1", 32'hFFFFFFFF, 32'd1, 1'b0, 1'b1);
        run_check("dz_signed", 32'h87654321, 32'd0, 1'b1, 1'b1);

        // Back-to-back: second start lands in the done cycle of the first.
        run_check("b2b_first", 32'd1000, 32'd3, 1'b0, 1'b0);
        run_check("b2b_second", 32'd77, 32'd5, 1'b0, 1'b1);

        // start while busy is ignored.
        model(32'd1000, 32'd7, 1'b0, eq, er, ez);
        issue(32'd1000, 32'd7, 1'b0);
        repeat (10) begin
            @(posedge clock);
            #1;
        end
        issue(32'd5, 32'd1, 1'b0);
        wait_done(lat, bc);
        chk("busy_start latency", 64'(lat + 11), 64'(W + 1));
        chk("busy_start q", 64'(bus.q), 64'(eq));
        chk("busy_start r", 64'(bus.r), 64'(er));

        // Reset in mid-operation.
        issue(32'd500, 32'd3, 1'b0);
        repeat (4) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("midrst busy", 64'(bus.busy), 64'(0));
        chk("midrst done", 64'(bus.done), 64'(0));
        chk("midrst q", 64'(bus.q), 64'(0));
        chk("midrst r", 64'(bus.r), 64'(0));
        dones = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (bus.done) dones++;
        end
        chk("midrst no_done", 64'(dones), 64'(0));

        // ena dropped mid-operation: abandon, keep previous result.
        run_check("pre_ena", 32'd123456, 32'd789, 1'b0, 1'b1);
        model(32'd123456, 32'd789, 1'b0, hold_q, hold_r, ez);
        issue(32'd999, 32'd4, 1'b0);
        repeat (5) begin
            @(posedge clock);
            #1;
        end
        bus.ena = 1'b0;
        @(posedge clock);
        #1;
        chk("ena0 busy", 64'(bus.busy), 64'(0));
        chk("ena0 done", 64'(bus.done), 64'(0));
        dones = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (bus.done) dones++;
        end
        chk("ena0 no_done", 64'(dones), 64'(0));
        chk("ena0 q_hold", 64'(bus.q), 64'(hold_q));
        chk("ena0 r_hold", 64'(bus.r), 64'(hold_r));
        chk("ena0 dz_hold", 64'(bus.div_zero), 64'(0));
        bus.ena = 1'b1;
        run_check("post_ena", -32'sd50, 32'd6, 1'b1, 1'b1);

        // Randomized operands against the arithmetic model.
        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = '0;
                1, 2:    b = W'($urandom_range(1, 20));
                3:       b = -W'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            s = 1'($urandom_range(0, 1));
            run_check($sformatf("rnd%0d", i), a, b, s, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
